// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared types, constants and the address error check for the
// memory responder (mem_responder, mem_resp_if, mem_resp_array).
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int WORD_BYTES = 4;
  localparam int BE_W       = 4;

  // An access faults if it is not word aligned or its word index is past the
  // end of the array. Address is zero-extended to 64 bits by the caller.
  function automatic logic addr_err(input logic [63:0] addr,
                                    input int unsigned depth_words);
    return (addr[1:0] != 2'b00) || ((addr >> 2) >= 64'(depth_words));
  endfunction

endpackage

// File: rtl/mem_resp_if.sv
// mem_resp_if: request/response bus between the core (master) and the
// memory responder (slave). One request in flight at a time.
interface mem_resp_if
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W = 32
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [BE_W-1:0]   be;
  logic [31:0]       rdata;
  logic              ack;
  logic              err;
  logic              busy;

  modport master (
    output req, we, addr, wdata, be,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output rdata, ack, err, busy
  );

endinterface

// File: rtl/mem_resp_array.sv
// mem_resp_array: word storage with per-byte write enables and a registered
// (synchronous) word read. No reset: contents survive a responder reset.
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic             rd_en_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [31:0]      wdata_i,
  input  logic [BE_W-1:0]  be_i,
  output logic [31:0]      rdata_o
);

  logic [BE_W-1:0][7:0] mem_q [DEPTH_WORDS];

  // Byte-lane write and registered read; the two are never issued together.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be_i[i]) mem_q[idx_i][i] <= wdata_i[8*i +: 8];
      end
    end
    if (rd_en_i) rdata_o <= mem_q[idx_i];
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: slave end of the core's unified memory bus. Captures one
// request, waits WAIT_STATES cycles, performs the access on the edge that
// enters RESP, then pulses ack for one cycle (with rdata or err).
// Optional feature macro: MEM_RESP_ERRCNT_EN adds a saturating 16-bit
// err_count output counting acks that carried err.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2,
  parameter int ADDR_W      = 32
) (
  input  logic       clk,
  input  logic       rst,
  mem_resp_if.slave  bus
`ifdef MEM_RESP_ERRCNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);
  localparam state_e CAP_NEXT = (WAIT_STATES > 0) ? WAIT : RESP;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              rd_ok_q, rd_ok_d;
  logic              err_q, err_d;

  logic              accept;
  logic              access;
  logic              use_live;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_we;
  logic [31:0]       acc_wdata;
  logic [BE_W-1:0]   acc_be;
  logic              acc_bad;
  logic [31:0]       arr_rdata;

  logic              ack_w, err_w, busy_w;
  logic [31:0]       rdata_w;

  // A new request is only taken when no access is in flight; RESP counts as
  // free so the core can issue in the ack cycle.
  assign accept = bus.req && ((state_q == IDLE) || (state_q == RESP));

  // The access fires on whatever edge moves us into RESP. From WAIT it uses
  // the latched request; with zero wait states the capture edge is also the
  // access edge, so the live bus fields are used instead.
  assign access    = (state_d == RESP);
  assign use_live  = (state_q != WAIT);
  assign acc_addr  = use_live ? bus.addr  : addr_q;
  assign acc_we    = use_live ? bus.we    : we_q;
  assign acc_wdata = use_live ? bus.wdata : wdata_q;
  assign acc_be    = use_live ? bus.be    : be_q;
  assign acc_bad   = addr_err(64'(acc_addr), DEPTH_WORDS);

  mem_resp_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (clk),
    .wr_en_i (access && acc_we && !acc_bad),
    .rd_en_i (access && !acc_we && !acc_bad),
    .idx_i   (acc_addr[IDX_W+1:2]),
    .wdata_i (acc_wdata),
    .be_i    (acc_be),
    .rdata_o (arr_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; req during WAIT is ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.req) state_d = CAP_NEXT;
      WAIT:    if (cnt_q == CNT_W'(1)) state_d = RESP;
      RESP:    state_d = bus.req ? CAP_NEXT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state; rdata only shows a good read.
  always_comb begin
    ack_w   = (state_q == RESP);
    busy_w  = (state_q != IDLE);
    err_w   = ack_w && err_q;
    rdata_w = (ack_w && rd_ok_q) ? arr_rdata : 32'h0;
  end

  assign bus.ack   = ack_w;
  assign bus.err   = err_w;
  assign bus.busy  = busy_w;
  assign bus.rdata = rdata_w;

  // Request latches, wait counter and response flags next-state.
  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rd_ok_d = rd_ok_q;
    err_d   = err_q;
    if (accept) begin
      cnt_d   = CNT_LOAD;
      addr_d  = bus.addr;
      we_d    = bus.we;
      wdata_d = bus.wdata;
      be_d    = bus.be;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (access) begin
      rd_ok_d = !acc_we && !acc_bad;
      err_d   = acc_bad;
    end
  end

  // Datapath registers; reset discards any captured request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_ok_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rd_ok_q <= rd_ok_d;
      err_q   <= err_d;
    end
  end

`ifdef MEM_RESP_ERRCNT_EN
  logic [15:0] errcnt_q;

  // Saturating count of faulted accesses, bumped in the ack cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 errcnt_q <= '0;
    else if (err_w && (errcnt_q != 16'hFFFF)) errcnt_q <= errcnt_q + 16'd1;
  end

  assign err_count = errcnt_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: two responders (WAIT_STATES=0 and =2) driven with directed
// and random traffic, checked every cycle against a byte-level memory model
// and a queue of expected responses.
module tb_mem_responder;

  typedef struct {
    int          issue;
    int          due;
    bit          err;
    bit          chk;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic        req_v   [2];
  logic        we_v    [2];
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic [3:0]  be_v    [2];

  logic        ack_w  [2];
  logic        err_w  [2];
  logic        busy_w [2];
  logic [31:0] rd_w   [2];

  exp_t        eq [2][$];
  logic [7:0]  mm [2][1024][4];
  bit          kn [2][1024][4];

  logic [31:0] last_rd  [2];
  logic        last_er  [2];
  int          last_cyc [2];

  mem_resp_if #(.ADDR_W(32)) b0 ();
  mem_resp_if #(.ADDR_W(32)) b1 ();

  assign b0.req = req_v[0];  assign b0.we = we_v[0];  assign b0.addr = addr_v[0];
  assign b0.wdata = wdata_v[0];  assign b0.be = be_v[0];
  assign b1.req = req_v[1];  assign b1.we = we_v[1];  assign b1.addr = addr_v[1];
  assign b1.wdata = wdata_v[1];  assign b1.be = be_v[1];

  assign ack_w[0] = b0.ack;  assign err_w[0] = b0.err;  assign busy_w[0] = b0.busy;  assign rd_w[0] = b0.rdata;
  assign ack_w[1] = b1.ack;  assign err_w[1] = b1.err;  assign busy_w[1] = b1.busy;  assign rd_w[1] = b1.rdata;

`ifdef MEM_RESP_ERRCNT_EN
  logic [15:0] ec0, ec1;
`endif

  mem_responder #(.WAIT_STATES(0)) u0 (
    .clk (clk), .rst (rst), .bus (b0)
`ifdef MEM_RESP_ERRCNT_EN
    , .err_count (ec0)
`endif
  );

  mem_responder #(.WAIT_STATES(2)) u1 (
    .clk (clk), .rst (rst), .bus (b1)
`ifdef MEM_RESP_ERRCNT_EN
    , .err_count (ec1)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[dut%0d] cyc=%0d got=%h want=%h", nm, k, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the expected-response queues.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit   ea, eb;
      exp_t e;
      if (!rst) begin
        chk("rst_ack", k, 32'(ack_w[k]), 32'h0);
        chk("rst_err", k, 32'(err_w[k]), 32'h0);
        chk("rst_busy", k, 32'(busy_w[k]), 32'h0);
        chk("rst_rdata", k, rd_w[k], 32'h0);
      end else begin
        ea = (eq[k].size() > 0) && (eq[k][0].due == cyc);
        eb = (eq[k].size() > 0) && (cyc > eq[k][0].issue);
        chk("ack", k, 32'(ack_w[k]), 32'(ea));
        chk("busy", k, 32'(busy_w[k]), 32'(eb));
        if (ea) begin
          e = eq[k].pop_front();
          chk("err", k, 32'(err_w[k]), 32'(e.err));
          if (e.chk) chk("rdata", k, rd_w[k], e.data);
          last_rd[k]  = rd_w[k];
          last_er[k]  = err_w[k];
          last_cyc[k] = cyc;
        end
      end
    end
  end

  // Drive one request for one cycle and record what it must produce.
  task automatic issue(input int k, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b, input bit commit);
    exp_t e;
    int   wi;
    e.issue = cyc;
    e.due   = cyc + ((k == 1) ? 2 : 0) + 1;
    e.err   = (a[1:0] != 2'b00) || ((a >> 2) >= 32'd1024);
    e.data  = 32'h0;
    e.chk   = 1'b1;
    if (!e.err) begin
      wi = int'(a >> 2);
      if (w) begin
        if (commit) begin
          for (int i = 0; i < 4; i++) begin
            if (b[i]) begin
              mm[k][wi][i] = d[8*i +: 8];
              kn[k][wi][i] = 1'b1;
            end
          end
        end
      end else begin
        e.data = {mm[k][wi][3], mm[k][wi][2], mm[k][wi][1], mm[k][wi][0]};
        e.chk  = kn[k][wi][0] && kn[k][wi][1] && kn[k][wi][2] && kn[k][wi][3];
      end
    end
    eq[k].push_back(e);
    req_v[k] = 1'b1;  we_v[k] = w;  addr_v[k] = a;  wdata_v[k] = d;  be_v[k] = b;
    @(posedge clk); #1;
    req_v[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while (eq[k].size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (eq[k].size() != 0) begin
      bad++;
      $display("FAIL wait_idle[dut%0d] pending=%0d want=0", k, eq[k].size());
      eq[k].delete();
    end
  endtask

  // Wait until the DUT may take a new request (idle or in its ack cycle).
  task automatic wait_slot(input int k);
    int n = 0;
    while (eq[k].size() != 0 && eq[k][eq[k].size()-1].due != cyc && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n >= 100) begin
      bad++;
      $display("FAIL wait_slot[dut%0d] timed out", k);
      eq[k].delete();
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 9);
    logic [31:0] wd = 32'($urandom_range(0, 15));
    if (r == 0) return (wd << 2) | 32'($urandom_range(1, 3));
    if (r == 1) return (32'd1024 + 32'($urandom_range(0, 3000))) << 2;
    if (r == 2) return 32'd1023 << 2;
    return wd << 2;
  endfunction

  initial begin
    int ic;
    for (int k = 0; k < 2; k++) begin
      req_v[k] = 1'b0;  we_v[k] = 1'b0;  addr_v[k] = '0;  wdata_v[k] = '0;  be_v[k] = '0;
      last_rd[k] = '0;  last_er[k] = 1'b0;  last_cyc[k] = 0;
    end
    #32 rst = 1'b1;
    @(posedge clk); #1;

    // Full write then read, WAIT_STATES=2 latency.
    ic = cyc;
    issue(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
    wait_idle(1);
    chk("lat_wr", 1, 32'(last_cyc[1] - ic), 32'd3);
    chk("wr_err", 1, 32'(last_er[1]), 32'd0);
    issue(1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
    wait_idle(1);
    chk("rd_lit", 1, last_rd[1], 32'hDEADBEEF);

    // Partial write lanes 0 and 2.
    issue(1, 1'b1, 32'h10, 32'h11223344, 4'b0101, 1'b1);
    wait_idle(1);
    chk("model_pin", 1, {mm[1][4][3], mm[1][4][2], mm[1][4][1], mm[1][4][0]}, 32'hDE22BE44);
    issue(1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
    wait_idle(1);
    chk("part_lit", 1, last_rd[1], 32'hDE22BE44);

    // be=0 write is a clean no-op.
    issue(1, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 1'b1);
    wait_idle(1);
    chk("be0_err", 1, 32'(last_er[1]), 32'd0);

    // Misaligned read and out-of-range write.
    issue(1, 1'b0, 32'h12, 32'h0, 4'h0, 1'b1);
    wait_idle(1);
    chk("mis_err", 1, 32'(last_er[1]), 32'd1);
    chk("mis_rdata", 1, last_rd[1], 32'h0);
    issue(1, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 1'b1);
    wait_idle(1);
    issue(1, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 1'b1);
    wait_idle(1);
    chk("oor_err", 1, 32'(last_er[1]), 32'd1);
    issue(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    wait_idle(1);
    chk("oor_w0", 1, last_rd[1], 32'h0BADF00D);

    // Last word is legal.
    issue(1, 1'b1, 32'hFFC, 32'h5A5A1234, 4'hF, 1'b1);
    wait_idle(1);
    issue(1, 1'b0, 32'hFFC, 32'h0, 4'h0, 1'b1);
    wait_idle(1);
    chk("last_word", 1, last_rd[1], 32'h5A5A1234);
    chk("last_err", 1, 32'(last_er[1]), 32'd0);

    // Read issued in the ack cycle of a write to the same word.
    issue(1, 1'b1, 32'h40, 32'hA5A5C3C3, 4'hF, 1'b1);
    wait_slot(1);
    ic = cyc;
    issue(1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1);
    wait_idle(1);
    chk("b2b_lat", 1, 32'(last_cyc[1] - ic), 32'd3);
    chk("b2b_rd", 1, last_rd[1], 32'hA5A5C3C3);

    // Zero wait states: consecutive pulses, ack every cycle.
    for (int i = 0; i < 6; i++) issue(0, 1'b1, 32'(i * 4), 32'h1000_0000 + 32'(i), 4'hF, 1'b1);
    for (int i = 0; i < 6; i++) begin
      ic = cyc;
      issue(0, 1'b0, 32'(i * 4), 32'h0, 4'h0, 1'b1);
    end
    wait_idle(0);
    chk("ws0_lat", 0, 32'(last_cyc[0] - ic), 32'd1);
    chk("ws0_rd", 0, last_rd[0], 32'h1000_0005);

    // Reset in the first WAIT cycle kills the pending write.
    issue(1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b1);
    wait_idle(1);
    wait_idle(0);
    issue(1, 1'b1, 32'h20, 32'h12345678, 4'hF, 1'b0);
    eq[1].delete();
    rst = 1'b0;
    #1;
    chk("mid_ack", 1, 32'(ack_w[1]), 32'h0);
    chk("mid_err", 1, 32'(err_w[1]), 32'h0);
    chk("mid_busy", 1, 32'(busy_w[1]), 32'h0);
    chk("mid_rdata", 1, rd_w[1], 32'h0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
`ifdef MEM_RESP_ERRCNT_EN
    chk("ecnt_rst", 1, 32'(ec1), 32'd0);
    for (int i = 0; i < 3; i++) begin
      issue(1, 1'b0, 32'h21 + 32'(i), 32'h0, 4'h0, 1'b1);
      wait_idle(1);
    end
    chk("ecnt_3", 1, 32'(ec1), 32'd3);
`endif
    issue(1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1);
    wait_idle(1);
    chk("rst_keep", 1, last_rd[1], 32'hCAFEF00D);

    // Random traffic on both instances.
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 150; n++) begin
        wait_slot(k);
        if ($urandom_range(0, 2) == 0) begin
          for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
            @(posedge clk); #1;
          end
        end
        issue(k, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(0, 15)), 1'b1);
      end
      wait_idle(k);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
